// File: rtl/mem_lsu_master.sv
// mem_lsu_master: load/store initiator for a 64-bit word-addressed data memory.
// Takes byte-addressed load/store requests of 1/2/4/8 bytes over a valid/ready
// handshake. Loads are sign- or zero-extended. Sub-doubleword stores use
// read-modify-write, because the memory only writes whole words.
// Optional build macro: LSU_RANGE_CHECK_EN. When it is defined, a request whose
// word index is at or above 2**depth is rejected as an error and no memory
// access is made.
module mem_lsu_master #(
   parameter int width = 64,
   parameter int depth = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [width-1:0] req_addr,
   input  logic [width-1:0] req_wdata,
   output logic             resp_valid,
   output logic [width-1:0] resp_rdata,
   output logic             resp_err,
   output logic             memoryRead,
   output logic             memoryWri,
   output logic [width-1:0] address,
   output logic [width-1:0] dataWri,
   input  logic [width-1:0] dataRead
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_RESP = 3'd3,
      S_ERR  = 3'd4
   } state_e;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_DWORD = 2'b11;

   state_e           state_q, state_d;
   logic             write_q, write_d;
   logic [1:0]       size_q, size_d;
   logic             unsigned_q, unsigned_d;
   logic [2:0]       off_q, off_d;
   logic [width-1:0] wdata_q, wdata_d;
   logic [width-1:0] rdata_q, rdata_d;
   logic [width-1:0] address_q, address_d;
   logic [width-1:0] datawri_q, datawri_d;

   logic misaligned;
   logic out_of_range;

   // Mask covering the low size_bytes bytes, before it is moved to the lane.
   function automatic logic [width-1:0] lane_mask(input logic [1:0] size);
      logic [width-1:0] m;
      case (size)
         SZ_BYTE: m = {{(width-8){1'b0}},  8'hFF};
         SZ_HALF: m = {{(width-16){1'b0}}, 16'hFFFF};
         SZ_WORD: m = {{(width-32){1'b0}}, 32'hFFFF_FFFF};
         default: m = '1;
      endcase
      return m;
   endfunction

   // Replace the addressed lane of old_w with the low bytes of new_w.
   function automatic logic [width-1:0] merge_word(input logic [width-1:0] old_w,
                                                   input logic [width-1:0] new_w,
                                                   input logic [2:0]       off,
                                                   input logic [1:0]       size);
      logic [width-1:0] m;
      m = lane_mask(size) << {off, 3'b000};
      return (old_w & ~m) | ((new_w << {off, 3'b000}) & m);
   endfunction

   // Move the addressed lane down to bit 0, then sign- or zero-extend it.
   function automatic logic [width-1:0] extend_load(input logic [width-1:0] w,
                                                    input logic [2:0]       off,
                                                    input logic [1:0]       size,
                                                    input logic             uns);
      logic [width-1:0] s;
      logic [width-1:0] r;
      s = w >> {off, 3'b000};
      case (size)
         SZ_BYTE: r = uns ? {{(width-8){1'b0}}, s[7:0]}   : {{(width-8){s[7]}}, s[7:0]};
         SZ_HALF: r = uns ? {{(width-16){1'b0}}, s[15:0]} : {{(width-16){s[15]}}, s[15:0]};
         SZ_WORD: r = uns ? {{(width-32){1'b0}}, s[31:0]} : {{(width-32){s[31]}}, s[31:0]};
         default: r = s;
      endcase
      return r;
   endfunction

   // Alignment check on the incoming request: the low address bits must be zero for its size.
   always_comb begin
      misaligned = 1'b0;
      case (req_size)
         SZ_HALF:  misaligned = req_addr[0];
         SZ_WORD:  misaligned = |req_addr[1:0];
         SZ_DWORD: misaligned = |req_addr[2:0];
         default:  misaligned = 1'b0;
      endcase
   end

`ifdef LSU_RANGE_CHECK_EN
   // Any word-index bit at or above depth means the request lies beyond the memory.
   assign out_of_range = |req_addr[width-1:depth+3];
`else
   assign out_of_range = 1'b0;
`endif

   // State and datapath registers; reset clears everything, so any write in flight is aborted.
   // NOTE: sequential state uses non-blocking (<=) so every register samples its pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         write_q    <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         off_q      <= 3'b000;
         wdata_q    <= '0;
         rdata_q    <= '0;
         address_q  <= '0;
         datawri_q  <= '0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         size_q     <= size_d;
         unsigned_q <= unsigned_d;
         off_q      <= off_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         address_q  <= address_d;
         datawri_q  <= datawri_d;
      end
   end

   // Next state, request latching, and the registered address/write data for the next strobe.
   // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      size_d     = size_q;
      unsigned_d = unsigned_q;
      off_d      = off_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      address_d  = '0;
      datawri_d  = '0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d    = req_write;
               size_d     = req_size;
               unsigned_d = req_unsigned;
               off_d      = req_addr[2:0];
               wdata_d    = req_wdata;
               if (misaligned || out_of_range) begin
                  state_d = S_ERR;
               end else if (req_write && (req_size == SZ_DWORD)) begin
                  state_d   = S_WR;
                  address_d = req_addr >> 3;
                  datawri_d = req_wdata;
               end else begin
                  state_d   = S_RD;
                  address_d = req_addr >> 3;
               end
            end
         end
         S_RD: begin
            rdata_d = dataRead;
            if (write_q) begin
               state_d   = S_WR;
               address_d = address_q;
               datawri_d = merge_word(dataRead, wdata_q, off_q, size_q);
            end else begin
               state_d = S_RESP;
            end
         end
         S_WR:    state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes and the response are decoded from the state register.
   // NOTE: because they come straight from the async-reset state, memoryWri drops as soon as rst_n falls.
   always_comb begin
      req_ready  = (state_q == S_IDLE);
      memoryRead = (state_q == S_RD);
      memoryWri  = (state_q == S_WR);
      resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
      resp_err   = (state_q == S_ERR);
      resp_rdata = '0;
      if ((state_q == S_RESP) && !write_q) begin
         resp_rdata = extend_load(rdata_q, off_q, size_q, unsigned_q);
      end
   end

   assign address = address_q;
   assign dataWri = datawri_q;

endmodule

// File: tb/tb_mem_lsu_master.sv
// tb_mem_lsu_master: self-checking bench for mem_lsu_master. The DUT drives a
// 256-word memory. Each result is compared with a byte-array reference model.
module tb_mem_lsu_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        memoryRead;
   logic        memoryWri;
   logic [63:0] address;
   logic [63:0] dataWri;
   logic [63:0] dataRead;

   int total = 0;
   int bad = 0;

   logic [63:0] mem_words [0:255];
   logic [7:0]  ref_mem [0:2047];

   mem_lsu_master #(.width(64), .depth(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .memoryRead(memoryRead), .memoryWri(memoryWri),
      .address(address), .dataWri(dataWri), .dataRead(dataRead)
   );

   always #5 clk = ~clk;

   // The memory itself: combinational read, and a whole-word write on the clock edge.
   assign dataRead = mem_words[address[7:0]];
   always @(posedge clk) if (memoryWri) mem_words[address[7:0]] <= dataWri;

   // Reference load: gather the bytes little-endian, then extend by plain arithmetic.
   function automatic logic [63:0] ref_load(input int a, input int sz, input logic uns);
      logic [63:0] v;
      int nb;
      nb = 1 << sz;
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[a + i]) << (8 * i));
      if (!uns && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
      return v;
   endfunction

   task automatic ref_store(input int a, input int sz, input logic [63:0] wd);
      for (int i = 0; i < (1 << sz); i++) ref_mem[a + i] = wd[8*i +: 8];
   endtask

   function automatic logic [63:0] ref_word(input int idx);
      return ref_load(idx * 8, 3, 1'b1);
   endfunction

   // Drive one request and follow it to its response, recording the strobes seen.
   task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [63:0] ad, input logic [63:0] wd,
                         output logic [63:0] rdata, output logic err, output int lat,
                         output logic saw_rd, output logic saw_wr, output logic both,
                         output logic [63:0] rd_addr, output logic [63:0] wr_addr,
                         output logic [63:0] wr_data);
      int n;
      logic done;
      rdata = '0; err = 1'b0; lat = 0; saw_rd = 1'b0; saw_wr = 1'b0; both = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0; done = 1'b0;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (!req_ready) begin
         total++; bad++;
         $display("FAIL ready_timeout: req_ready=%0b required 1", req_ready);
      end
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = ad; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      while (!done && lat < 10) begin
         @(negedge clk);
         lat++;
         if (memoryRead && !saw_rd) begin saw_rd = 1'b1; rd_addr = address; end
         if (memoryWri && !saw_wr) begin saw_wr = 1'b1; wr_addr = address; wr_data = dataWri; end
         if (memoryRead && memoryWri) both = 1'b1;
         if (resp_valid) begin rdata = resp_rdata; err = resp_err; done = 1'b1; end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL resp_timeout: no resp_valid within %0d cycles, required a response", lat);
      end
   endtask

   task automatic test_reset();
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", req_ready); end
      total++; if ({resp_valid, resp_err, memoryRead, memoryWri} !== 4'b0) begin bad++;
         $display("FAIL reset_flags: got %b want 0000", {resp_valid, resp_err, memoryRead, memoryWri}); end
      total++; if (address !== 64'd0 || dataWri !== 64'd0 || resp_rdata !== 64'd0) begin bad++;
         $display("FAIL reset_data: addr=%h dataWri=%h rdata=%h want 0", address, dataWri, resp_rdata); end
   endtask

   task automatic test_dword();
      logic [63:0] rd, ra, wa, wdat; logic e, srd, swr, bo; int lat;
      do_req(1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788, rd, e, lat, srd, swr, bo, ra, wa, wdat);
      ref_store(16, 3, 64'h1122334455667788);
      total++; if ({swr, srd} !== 2'b10) begin bad++; $display("FAIL dw_strobes: wr=%0b rd=%0b want wr=1 rd=0", swr, srd); end
      total++; if (wa !== 64'd2) begin bad++; $display("FAIL dw_addr: got %0d want 2", wa); end
      total++; if (wdat !== 64'h1122334455667788) begin bad++; $display("FAIL dw_data: got %h want 1122334455667788", wdat); end
      total++; if (lat !== 2) begin bad++; $display("FAIL dw_store_lat: got %0d want 2", lat); end
      do_req(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, rd, e, lat, srd, swr, bo, ra, wa, wdat);
      total++; if (rd !== 64'h1122334455667788) begin bad++; $display("FAIL dw_load: got %h want 1122334455667788", rd); end
      total++; if (lat !== 2) begin bad++; $display("FAIL dw_load_lat: got %0d want 2", lat); end
   endtask

   task automatic test_byte_rmw();
      logic [63:0] rd, ra, wa, wdat; logic e, srd, swr, bo; int lat;
      do_req(1'b1, 2'b11, 1'b0, 64'h10, '1, rd, e, lat, srd, swr, bo, ra, wa, wdat);
      ref_store(16, 3, '1);
      do_req(1'b1, 2'b00, 1'b0, 64'h13, 64'hAB, rd, e, lat, srd, swr, bo, ra, wa, wdat);
      ref_store(19, 0, 64'hAB);
      total++; if ({srd, swr} !== 2'b11) begin bad++; $display("FAIL rmw_strobes: rd=%0b wr=%0b want 1 1", srd, swr); end
      total++; if (wdat !== 64'hFFFFFFFFABFFFFFF || wdat !== ref_word(2)) begin bad++;
         $display("FAIL rmw_data: got %h want FFFFFFFFABFFFFFF", wdat); end
      total++; if (lat !== 3) begin bad++; $display("FAIL rmw_lat: got %0d want 3", lat); end
   endtask

   task automatic test_load_ext();
      logic [63:0] rd, ra, wa, wdat; logic e, srd, swr, bo; int lat;
      do_req(1'b1, 2'b11, 1'b0, 64'h10, 64'h0000000080000000, rd, e, lat, srd, swr, bo, ra, wa, wdat);
      ref_store(16, 3, 64'h0000000080000000);
      do_req(1'b0, 2'b10, 1'b0, 64'h10, 64'h0, rd, e, lat, srd, swr, bo, ra, wa, wdat);
      total++; if (rd !== 64'hFFFFFFFF80000000) begin bad++; $display("FAIL ext_word_s: got %h want FFFFFFFF80000000", rd); end
      do_req(1'b0, 2'b10, 1'b1, 64'h10, 64'h0, rd, e, lat, srd, swr, bo, ra, wa, wdat);
      total++; if (rd !== 64'h0000000080000000) begin bad++; $display("FAIL ext_word_u: got %h want 0000000080000000", rd); end
      do_req(1'b0, 2'b00, 1'b0, 64'h13, 64'h0, rd, e, lat, srd, swr, bo, ra, wa, wdat);
      total++; if (rd !== 64'hFFFFFFFFFFFFFF80) begin bad++; $display("FAIL ext_byte_s: got %h want FFFFFFFFFFFFFF80", rd); end
   endtask

   task automatic test_misaligned();
      logic [63:0] rd, ra, wa, wdat; logic e, srd, swr, bo; int lat;
      do_req(1'b0, 2'b01, 1'b0, 64'h11, 64'h0, rd, e, lat, srd, swr, bo, ra, wa, wdat);
      total++; if (e !== 1'b1 || rd !== 64'd0) begin bad++; $display("FAIL mis_err: err=%0b rdata=%h want 1 0", e, rd); end
      total++; if (lat !== 1) begin bad++; $display("FAIL mis_lat: got %0d want 1", lat); end
      total++; if ({srd, swr} !== 2'b00) begin bad++; $display("FAIL mis_strobes: rd=%0b wr=%0b want 0 0", srd, swr); end
   endtask

   task automatic test_random();
      logic [63:0] rd, ra, wa, wdat, wd, exp; logic e, srd, swr, bo, wr, uns, exp_err; int lat, a, sz, nb, exp_lat;
      for (int it = 0; it < 80; it++) begin
         wr = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
         sz = $urandom_range(0, 3); nb = 1 << sz;
         a = $urandom_range(0, 2047);
         if ($urandom_range(0, 3) != 0) a = a - (a % nb);
         wd = {$urandom, $urandom};
         exp_err = (a % nb) != 0;
         exp_lat = exp_err ? 1 : ((wr && sz != 3) ? 3 : 2);
         do_req(wr, 2'(sz), uns, 64'(a), wd, rd, e, lat, srd, swr, bo, ra, wa, wdat);
         total++; if (e !== exp_err || lat !== exp_lat || bo !== 1'b0) begin bad++;
            $display("FAIL rnd_ctl[%0d]: err=%0b lat=%0d both=%0b want err=%0b lat=%0d both=0", it, e, lat, bo, exp_err, exp_lat); end
         total++; if (srd !== (!exp_err && !(wr && sz == 3)) || swr !== (!exp_err && wr)) begin bad++;
            $display("FAIL rnd_strobes[%0d]: rd=%0b wr=%0b (write=%0b size=%0d addr=%h)", it, srd, swr, wr, sz, a); end
         exp = '0;
         if (!exp_err && !wr) exp = ref_load(a, sz, uns);
         total++; if (rd !== exp) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", it, rd, exp); end
         if (!exp_err && wr) begin
            ref_store(a, sz, wd);
            total++; if (wdat !== ref_word(a / 8) || wa !== 64'(a / 8)) begin bad++;
               $display("FAIL rnd_store[%0d]: addr=%0d data=%h want addr=%0d data=%h", it, wa, wdat, a / 8, ref_word(a / 8)); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int rdy, rsp;
      rdy = 0; rsp = 0;
      @(negedge clk);
      while (!req_ready) @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b11; req_unsigned = 1'b0; req_addr = 64'h10;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         if (req_ready) rdy++;
         if (resp_valid) rsp++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      total++; if (rdy !== 3 || rsp !== 3) begin bad++; $display("FAIL b2b: ready=%0d resp=%0d want 3 3", rdy, rsp); end
   endtask

   task automatic test_reset_mid_store();
      logic [63:0] rd, ra, wa, wdat; logic e, srd, swr, bo; int lat, n;
      do_req(1'b1, 2'b11, 1'b0, 64'h18, 64'h0123456789ABCDEF, rd, e, lat, srd, swr, bo, ra, wa, wdat);
      ref_store(24, 3, 64'h0123456789ABCDEF);
      @(negedge clk);
      while (!req_ready) @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 64'h19; req_wdata = 64'h55;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      while (!memoryWri && n < 5) begin @(negedge clk); n++; end
      total++; if (memoryWri !== 1'b1) begin bad++; $display("FAIL rst_reach_wr: memoryWri=%0b want 1", memoryWri); end
      rst_n = 1'b0;
      #1;
      total++; if ({memoryWri, memoryRead, resp_valid, resp_err} !== 4'b0 || address !== 64'd0 || dataWri !== 64'd0 || resp_rdata !== 64'd0) begin bad++;
         $display("FAIL rst_outputs: flags=%b addr=%h dataWri=%h rdata=%h want 0", {memoryWri, memoryRead, resp_valid, resp_err}, address, dataWri, resp_rdata); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b want 1", req_ready); end
      do_req(1'b0, 2'b11, 1'b0, 64'h18, 64'h0, rd, e, lat, srd, swr, bo, ra, wa, wdat);
      total++; if (rd !== ref_word(3)) begin bad++; $display("FAIL rst_mem_kept: got %h want %h", rd, ref_word(3)); end
   endtask

   task automatic test_range();
      logic [63:0] rd, ra, wa, wdat; logic e, srd, swr, bo; int lat;
      do_req(1'b0, 2'b11, 1'b0, 64'h800, 64'h0, rd, e, lat, srd, swr, bo, ra, wa, wdat);
`ifdef LSU_RANGE_CHECK_EN
      total++; if (e !== 1'b1 || {srd, swr} !== 2'b00 || lat !== 1) begin bad++;
         $display("FAIL range_err: err=%0b rd=%0b wr=%0b lat=%0d want 1 0 0 1", e, srd, swr, lat); end
`else
      total++; if (e !== 1'b0 || srd !== 1'b1 || ra !== 64'd256 || lat !== 2) begin bad++;
         $display("FAIL range_pass: err=%0b rd=%0b addr=%0d lat=%0d want 0 1 256 2", e, srd, ra, lat); end
`endif
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_words[i] = '0;
      for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_dword();
      test_byte_rmw();
      test_load_ext();
      test_misaligned();
      test_back_to_back();
      test_reset_mid_store();
      test_range();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
